// File: rtl/stp_loader_param_pkg.sv
// Shared types, status codes and helpers for the parametrised STP loader.
package stp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      STREAM,
      WR_N,
      ERROR,
      END
   } stp_state_e;

   localparam logic [31:0] STP_OK       = 32'd0;
   localparam logic [31:0] STP_ERR_DEG  = 32'd1;
   localparam logic [31:0] STP_ERR_VEC  = 32'd2;
   localparam logic [31:0] STATUS_RESET = 32'hFFFF_FFFF;

   // Ceiling log2, never below 1 so that depth-1 memories still get a real bus.
   function automatic int log2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/stp_loader_param_if.sv
// RAM and FIFO side of the STP loader: data RAM read, S/N RAM write, result/status FIFO push.
interface stp_loader_param_if
   import stp_pkg::*;
#(
   parameter int word_size   = 16,
   parameter int buffer_size = 1024,
   parameter int n_size      = 8,
   parameter int max_deg     = 10,
   parameter int n_width     = 5
) ();

   localparam int AW = log2(buffer_size);
   localparam int VW = log2(n_size);
   localparam int CW = log2(max_deg + 1);

   logic                 en_rd_data;
   logic [AW-1:0]        rd_addr_data_updated;
   logic [word_size-1:0] next_c;
   logic                 en_wr_S;
   logic [VW-1:0]        wr_addr_S_vec;
   logic [CW-1:0]        wr_addr_S_coef;
   logic [word_size-1:0] c;
   logic                 en_wr_N;
   logic [VW-1:0]        wr_addr_N;
   logic [n_width-1:0]   N_out;
   logic [31:0]          result;
   logic [31:0]          status;
   logic                 fifo_wr_en_r;
   logic                 fifo_wr_en_s;

   modport master (
      output en_rd_data, rd_addr_data_updated,
      input  next_c,
      output en_wr_S, wr_addr_S_vec, wr_addr_S_coef, c,
      output en_wr_N, wr_addr_N, N_out,
      output result, status, fifo_wr_en_r, fifo_wr_en_s
   );

   modport slave (
      input  en_rd_data, rd_addr_data_updated,
      output next_c,
      input  en_wr_S, wr_addr_S_vec, wr_addr_S_coef, c,
      input  en_wr_N, wr_addr_N, N_out,
      input  result, status, fifo_wr_en_r, fifo_wr_en_s
   );

endinterface

// File: rtl/stp_loader_param_coef_pipe.sv
// Read/write counter pair: issues wrapped data-RAM reads and retires each word
// into the S RAM one cycle later, when the RAM's read data is valid.
module stp_coef_pipe
   import stp_pkg::*;
#(
   parameter int word_size   = 16,
   parameter int buffer_size = 1024,
   parameter int max_deg     = 10,
   parameter int n_width     = 5,
   localparam int AW = log2(buffer_size),
   localparam int CW = log2(max_deg + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 active,
   input  logic [AW-1:0]        base,
   input  logic [n_width-1:0]   n,
   input  logic [word_size-1:0] next_c,
   output logic                 rd_en,
   output logic [AW-1:0]        rd_addr,
   output logic                 wr_en,
   output logic [CW-1:0]        wr_coef,
   output logic [word_size-1:0] wr_data,
   output logic                 last_wr
);

   logic [AW-1:0]      rd_addr_q, rd_addr_d;
   logic [n_width:0]   k_q, k_d;
   logic               wr_valid_q, wr_valid_d;
   logic [n_width-1:0] j_q, j_d;

   // After the last read rd_addr_q already holds base+N+1, so it doubles as the final pointer.
   always_comb begin
      rd_addr_d  = rd_addr_q;
      k_d        = k_q;
      j_d        = j_q;
      wr_valid_d = 1'b0;
      rd_en      = active && (k_q <= {1'b0, n});
      if (load) begin
         rd_addr_d = base;
         k_d       = '0;
         j_d       = '0;
      end else if (active) begin
         wr_valid_d = rd_en;
         if (rd_en) begin
            rd_addr_d = (rd_addr_q == AW'(buffer_size - 1)) ? '0 : rd_addr_q + 1'b1;
            k_d       = k_q + 1'b1;
            j_d       = k_q[n_width-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr_q  <= '0;
         k_q        <= '0;
         wr_valid_q <= 1'b0;
         j_q        <= '0;
      end else begin
         rd_addr_q  <= rd_addr_d;
         k_q        <= k_d;
         wr_valid_q <= wr_valid_d;
         j_q        <= j_d;
      end
   end

   assign rd_addr = rd_addr_q;
   assign wr_en   = wr_valid_q;
   assign wr_coef = wr_valid_q ? j_q[CW-1:0] : '0;
   assign wr_data = wr_valid_q ? next_c : '0;
   assign last_wr = wr_valid_q && (j_q == n);

endmodule

// File: rtl/stp_loader_param.sv
// STP(A, N) executor: validates A/N, streams N+1 coefficients into S row A,
// records the degree in the N RAM and reports one result/status word pair.
module stp_loader_param
   import stp_pkg::*;
#(
   parameter int word_size   = 16,
   parameter int buffer_size = 1024,
   parameter int n_size      = 8,
   parameter int max_deg     = 10,
   parameter int n_width     = 5,
   localparam int AW = log2(buffer_size),
   localparam int VW = log2(n_size),
   localparam int CW = log2(max_deg + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_stp,
   input  logic [AW-1:0]       rd_addr_data,
   input  logic [VW-1:0]       A,
   input  logic [n_width-1:0]  N,
   output logic                done_stp,
   stp_loader_param_if.master  bus
);

   stp_state_e         state_q, state_d;
   logic [VW-1:0]      a_q, a_d;
   logic [n_width-1:0] n_q, n_d;
   logic [31:0]        err_q, err_d;
   logic [31:0]        result_q, result_d;
   logic [31:0]        status_q, status_d;
   logic               load;
   logic               rd_en;
   logic               wr_en;
   logic               last_wr;
   logic [AW-1:0]      rd_addr;
   logic [CW-1:0]      wr_coef;
   logic [word_size-1:0] wr_data;

   // Vector index is checked before degree so a doubly-bad instruction reports code 2.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      n_d      = n_q;
      err_d    = err_q;
      result_d = result_q;
      status_d = status_q;
      load     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_stp) begin
               a_d     = A;
               n_d     = N;
               load    = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (32'(a_q) >= 32'(n_size)) begin
               err_d   = STP_ERR_VEC;
               state_d = ERROR;
            end else if (32'(n_q) > 32'(max_deg)) begin
               err_d   = STP_ERR_DEG;
               state_d = ERROR;
            end else begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (last_wr) state_d = WR_N;
         end
         WR_N: begin
            result_d = 32'd1;
            status_d = STP_OK;
            state_d  = END;
         end
         ERROR: begin
            result_d = 32'd0;
            status_d = err_q;
            state_d  = END;
         end
         END: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         n_q      <= '0;
         err_q    <= STP_OK;
         result_q <= 32'd0;
         status_q <= STATUS_RESET;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         n_q      <= n_d;
         err_q    <= err_d;
         result_q <= result_d;
         status_q <= status_d;
      end
   end

   stp_coef_pipe #(
      .word_size   (word_size),
      .buffer_size (buffer_size),
      .max_deg     (max_deg),
      .n_width     (n_width)
   ) u_coef_pipe (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .active  (state_q == STREAM),
      .base    (rd_addr_data),
      .n       (n_q),
      .next_c  (bus.next_c),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .wr_en   (wr_en),
      .wr_coef (wr_coef),
      .wr_data (wr_data),
      .last_wr (last_wr)
   );

   assign done_stp                 = (state_q == END);
   assign bus.fifo_wr_en_r         = (state_q == END);
   assign bus.fifo_wr_en_s         = (state_q == END);
   assign bus.en_rd_data           = rd_en;
   assign bus.rd_addr_data_updated = rd_addr;
   assign bus.en_wr_S              = wr_en;
   assign bus.wr_addr_S_vec        = wr_en ? a_q : '0;
   assign bus.wr_addr_S_coef       = wr_coef;
   assign bus.c                    = wr_data;
   assign bus.en_wr_N              = (state_q == WR_N);
   assign bus.wr_addr_N            = (state_q == WR_N) ? a_q : '0;
   assign bus.N_out                = (state_q == WR_N) ? n_q : '0;
   assign bus.result               = result_q;
   assign bus.status               = status_q;

endmodule

// File: tb/tb_stp_loader_param.sv
// Randomised self-checking bench for stp_loader_param against an instruction-level model
// with buffer_size=16 (wrap coverage) and n_size=6 (non power-of-two vector range).
module tb_stp_loader_param;

   localparam int WS  = 16;
   localparam int BUF = 16;
   localparam int NS  = 6;
   localparam int MD  = 10;
   localparam int NW  = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_stp;
   logic [3:0]  rd_addr_data;
   logic [2:0]  A;
   logic [4:0]  N;
   logic        done_stp;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] mem [BUF];

   int s_vec_q[$];
   int s_coef_q[$];
   int s_val_q[$];
   int n_addr_q[$];
   int n_val_q[$];
   int rd_q[$];
   int r_push_cnt = 0;
   int s_push_cnt = 0;
   logic [31:0] last_r_push = '0;
   logic [31:0] last_s_push = '0;
   logic        rd_pending  = 1'b0;
   logic [3:0]  rd_addr_l   = '0;

   stp_loader_param_if #(
      .word_size(WS), .buffer_size(BUF), .n_size(NS), .max_deg(MD), .n_width(NW)
   ) bus ();

   stp_loader_param #(
      .word_size(WS), .buffer_size(BUF), .n_size(NS), .max_deg(MD), .n_width(NW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_stp    (start_stp),
      .rd_addr_data (rd_addr_data),
      .A            (A),
      .N            (N),
      .done_stp     (done_stp),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   // Bench-side RAM/FIFO observer: log every write and push seen mid-cycle.
   always @(negedge clk) begin
      rd_pending = bus.en_rd_data;
      rd_addr_l  = bus.rd_addr_data_updated;
      if (bus.en_rd_data) rd_q.push_back(int'(bus.rd_addr_data_updated));
      if (bus.en_wr_S) begin
         s_vec_q.push_back(int'(bus.wr_addr_S_vec));
         s_coef_q.push_back(int'(bus.wr_addr_S_coef));
         s_val_q.push_back(int'(bus.c));
      end
      if (bus.en_wr_N) begin
         n_addr_q.push_back(int'(bus.wr_addr_N));
         n_val_q.push_back(int'(bus.N_out));
      end
      if (bus.fifo_wr_en_r) begin
         r_push_cnt++;
         last_r_push = bus.result;
      end
      if (bus.fifo_wr_en_s) begin
         s_push_cnt++;
         last_s_push = bus.status;
      end
   end

   // Data RAM with one cycle of read latency; junk when no read is outstanding.
   always @(posedge clk) begin
      if (rd_pending) bus.next_c = mem[rd_addr_l];
      else            bus.next_c = 16'($urandom);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic waitDone(output int cycles);
      cycles = 0;
      while (done_stp !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic fillMem();
      for (int i = 0; i < BUF; i++) mem[i] = 16'($urandom);
   endtask

   task automatic applyStimulus(input int base, input int a, input int n);
      int s0, n0, r0, p0, q0, cyc, err, nw, ptr;
      s0 = s_vec_q.size();
      n0 = n_addr_q.size();
      r0 = rd_q.size();
      p0 = r_push_cnt;
      q0 = s_push_cnt;
      err = (a >= NS) ? 2 : ((n > MD) ? 1 : 0);
      nw  = (err == 0) ? n + 1 : 0;
      ptr = (err == 0) ? (base + n + 1) % BUF : base;
      @(negedge clk);
      rd_addr_data = 4'(base);
      A            = 3'(a);
      N            = 5'(n);
      start_stp    = 1'b1;
      @(negedge clk);
      start_stp = 1'b0;
      waitDone(cyc);
      checkOutput("done_seen", {31'd0, done_stp}, 32'd1);
      if (err == 0) checkOutput("latency", cyc + 1, n + 5);
      else          checkOutput("err_latency_ok", {31'd0, (cyc + 1) <= 4}, 32'd1);
      checkOutput("result", bus.result, (err == 0) ? 32'd1 : 32'd0);
      checkOutput("status", bus.status, err);
      @(negedge clk);
      #1;
      checkOutput("pointer", {28'd0, bus.rd_addr_data_updated}, ptr);
      checkOutput("r_push", r_push_cnt - p0, 1);
      checkOutput("s_push", s_push_cnt - q0, 1);
      checkOutput("r_push_val", last_r_push, (err == 0) ? 32'd1 : 32'd0);
      checkOutput("s_push_val", last_s_push, err);
      checkOutput("rd_count", rd_q.size() - r0, nw);
      checkOutput("s_wr_count", s_vec_q.size() - s0, nw);
      checkOutput("n_wr_count", n_addr_q.size() - n0, (err == 0) ? 1 : 0);
      if (err == 0) begin
         for (int i = 0; i <= n; i++) begin
            checkOutput("rd_addr", rd_q[r0 + i], (base + i) % BUF);
            checkOutput("s_vec", s_vec_q[s0 + i], a);
            checkOutput("s_coef", s_coef_q[s0 + i], i);
            checkOutput("s_data", s_val_q[s0 + i], int'(mem[(base + i) % BUF]));
         end
         checkOutput("n_addr", n_addr_q[n0], a);
         checkOutput("n_val", n_val_q[n0], n);
      end
   endtask

   initial begin
      int cyc, p0, q0, s0, b0;
      rst          = 1'b1;
      start_stp    = 1'b0;
      rd_addr_data = '0;
      A            = '0;
      N            = '0;
      fillMem();
      #1;
      checkOutput("rst_status", bus.status, 32'hFFFF_FFFF);
      checkOutput("rst_result", bus.result, 32'd0);
      checkOutput("rst_done", {31'd0, done_stp}, 32'd0);
      checkOutput("rst_pointer", {28'd0, bus.rd_addr_data_updated}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Directed cases
      mem[5] = 16'h0011; mem[6] = 16'h0022; mem[7] = 16'h0033; mem[8] = 16'h0044;
      applyStimulus(5, 2, 3);
      applyStimulus(4, 1, 11);
      applyStimulus(7, 6, 2);
      applyStimulus(7, 6, 12);
      fillMem();
      applyStimulus(14, 5, 10);
      applyStimulus(15, 0, 0);
      applyStimulus(9, 3, 0);

      // Asynchronous reset at STREAM cycle t=2 of an N=5 instruction
      fillMem();
      @(negedge clk);
      rd_addr_data = 4'd3; A = 3'd4; N = 5'd5; start_stp = 1'b1;
      @(negedge clk);
      start_stp = 1'b0;
      cyc = 1;
      while (cyc < 4) begin
         @(negedge clk);
         cyc++;
      end
      #1;
      checkOutput("pre_rst_rd", {31'd0, bus.en_rd_data}, 32'd1);
      p0 = r_push_cnt; q0 = s_push_cnt; s0 = s_vec_q.size(); b0 = n_addr_q.size();
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_en_rd", {31'd0, bus.en_rd_data}, 32'd0);
      checkOutput("mid_rst_en_wr", {30'd0, bus.en_wr_S, bus.en_wr_N}, 32'd0);
      checkOutput("mid_rst_push", {30'd0, bus.fifo_wr_en_r, bus.fifo_wr_en_s}, 32'd0);
      checkOutput("mid_rst_done", {31'd0, done_stp}, 32'd0);
      checkOutput("mid_rst_ptr", {28'd0, bus.rd_addr_data_updated}, 32'd0);
      checkOutput("mid_rst_coef", {28'd0, bus.wr_addr_S_coef}, 32'd0);
      checkOutput("mid_rst_c", {16'd0, bus.c}, 32'd0);
      checkOutput("mid_rst_result", bus.result, 32'd0);
      checkOutput("mid_rst_status", bus.status, 32'hFFFF_FFFF);
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      checkOutput("post_rst_pushes", (r_push_cnt - p0) + (s_push_cnt - q0), 0);
      checkOutput("post_rst_writes", (s_vec_q.size() - s0) + (n_addr_q.size() - b0), 0);
      applyStimulus(3, 4, 5);

      // start_stp held high: one execution per pass through IDLE
      fillMem();
      p0 = r_push_cnt; q0 = s_push_cnt; s0 = s_vec_q.size();
      @(negedge clk);
      rd_addr_data = 4'd2; A = 3'd3; N = 5'd2; start_stp = 1'b1;
      waitDone(cyc);
      checkOutput("hold_first_latency", cyc, 2 + 5);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         waitDone(cyc);
         checkOutput("hold_gap", cyc + 1, 2 + 6);
      end
      start_stp = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      checkOutput("hold_r_push", r_push_cnt - p0, 3);
      checkOutput("hold_s_push", s_push_cnt - q0, 3);
      checkOutput("hold_s_writes", s_vec_q.size() - s0, 3 * 3);

      // Randomised instructions, including illegal vectors and degrees
      for (int it = 0; it < 14; it++) begin
         fillMem();
         applyStimulus($urandom_range(0, BUF - 1), $urandom_range(0, 7), $urandom_range(0, 12));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
